// File: rtl/mux_pkg.sv
// Shared constants, select-width helper and default stage record for the
// registered N:1 selector.
package mux_pkg;

    localparam int MUX_DEF_WIDTH = 16;
    localparam int MUX_MAX_IN    = 16;

    // Select width for n inputs: ceil(log2(n)), never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [MUX_DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/mux_pipe_stage.sv
// One register stage of the selector pipeline: async clear, flush beats stall.
module mux_pipe_stage
    import mux_pkg::*;
#(
    parameter type stage_t_p = stage_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     flush,
    input  stage_t_p d,
    output stage_t_p q
);

    stage_t_p q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (flush) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mux_n_1_pipe.sv
// Parametrised N:1 selector with LATENCY register stages, stall and flush.
// Define MUX_SEL_ERR_STICKY_EN to make sel_err sticky until rst or flush.
module mux_n_1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH   = MUX_DEF_WIDTH,
    parameter  int N_IN    = 3,
    parameter  int LATENCY = 1,
    localparam int SEL_W   = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic                  sel_err
);

    if (LATENCY < 1 || LATENCY > 2) begin : g_bad_latency
        $error("mux_n_1_pipe: LATENCY must be 1 or 2");
    end
    if (N_IN < 2 || N_IN > MUX_MAX_IN) begin : g_bad_n_in
        $error("mux_n_1_pipe: N_IN must be 2..16");
    end

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WIDTH-1:0] data;
    } stage_w_t;

    stage_w_t         stage_d;
    stage_w_t         chain [LATENCY+1];
    stage_w_t         last;
    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;

    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    // Out-of-range selects carry zero data but still occupy a valid slot.
    always_comb begin
        stage_d = '0;
        if (in_valid) begin
            stage_d.valid = 1'b1;
            stage_d.err   = ~sel_hit;
            stage_d.data  = sel_data;
        end
    end

    assign chain[0] = stage_d;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        mux_pipe_stage #(
            .stage_t_p (stage_w_t)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .flush (flush),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign last      = chain[LATENCY];
    assign out       = last.data;
    assign out_valid = last.valid;

`ifdef MUX_SEL_ERR_STICKY_EN
    logic err_sticky_q;
    logic err_sticky_d;

    // OR-ing in the live bit lets the flag rise with the offending word.
    always_comb begin
        err_sticky_d = err_sticky_q | last.err;
        if (flush) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign sel_err = err_sticky_q | last.err;
`else
    assign sel_err = last.err;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Randomised and directed bench for mux_n_1_pipe against a word-history model.
module tb_mux_n_1_pipe;

    logic        clk = 1'b0;
    logic        rst, en, flush, in_valid;
    logic [1:0]  sel;
    logic [47:0] in_bus;
    logic [2:0]  sel8;
    logic [63:0] bus8;
    logic [15:0] out1, out2;
    logic [7:0]  out3;
    logic        v1, v2, v3, e1, e2, e3;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [15:0] d;
    } w_t;

    w_t h1[$];
    w_t h2[$];
    w_t h3[$];
    bit stk1, stk2, stk3;

    always #5 clk = ~clk;

    mux_n_1_pipe #(.WIDTH(16), .N_IN(3), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .sel(sel), .in_bus(in_bus), .out(out1), .out_valid(v1), .sel_err(e1));

    mux_n_1_pipe #(.WIDTH(16), .N_IN(3), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .sel(sel), .in_bus(in_bus), .out(out2), .out_valid(v2), .sel_err(e2));

    mux_n_1_pipe #(.WIDTH(8), .N_IN(8), .LATENCY(1)) dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .sel(sel8), .in_bus(bus8), .out(out3), .out_valid(v3), .sel_err(e3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The word a selector of n inputs of width w should launch for these inputs.
    function automatic w_t word(input bit iv, input int s, input logic [63:0] bus,
                                input int n, input int w);
        w_t r;
        r = '0;
        if (!iv) return r;
        r.v = 1'b1;
        if (s >= n) begin
            r.e = 1'b1;
            return r;
        end
        r.d = 16'((bus >> (s * w)) & ((64'd1 << w) - 64'd1));
        return r;
    endfunction

    task automatic model_reset();
        h1 = {}; h2 = {}; h3 = {};
        h1.push_back('0);
        h2.push_back('0); h2.push_back('0);
        h3.push_back('0);
        stk1 = 0; stk2 = 0; stk3 = 0;
    endtask

    // Each enabled edge appends the accepted word; output = word LATENCY-1 entries back.
    task automatic model_edge();
        if (flush) begin
            h1.push_back('0);
            h2.push_back('0); h2.push_back('0);
            h3.push_back('0);
            stk1 = 0; stk2 = 0; stk3 = 0;
        end else begin
            if (en) begin
                h1.push_back(word(in_valid, int'(sel), {16'h0, in_bus}, 3, 16));
                h2.push_back(word(in_valid, int'(sel), {16'h0, in_bus}, 3, 16));
                h3.push_back(word(in_valid, int'(sel8), bus8, 8, 8));
            end
            if (h1[$].e) stk1 = 1;
            if (h2[$-1].e) stk2 = 1;
            if (h3[$].e) stk3 = 1;
        end
    endtask

    task automatic check_all();
        w_t x1, x2, x3;
        bit xe1, xe2, xe3;
        x1 = h1[$];
        x2 = h2[$-1];
        x3 = h3[$];
`ifdef MUX_SEL_ERR_STICKY_EN
        xe1 = stk1; xe2 = stk2; xe3 = stk3;
`else
        xe1 = x1.e; xe2 = x2.e; xe3 = x3.e;
`endif
        chk("l1_out",   32'(out1), 32'(x1.d));
        chk("l1_valid", 32'(v1),   32'(x1.v));
        chk("l1_err",   32'(e1),   32'(xe1));
        chk("l2_out",   32'(out2), 32'(x2.d));
        chk("l2_valid", 32'(v2),   32'(x2.v));
        chk("l2_err",   32'(e2),   32'(xe2));
        chk("n8_out",   32'(out3), 32'(x3.d[7:0]));
        chk("n8_valid", 32'(v3),   32'(x3.v));
        chk("n8_err",   32'(e3),   32'(xe3));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    // Reset raised between edges must clear outputs before any further edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sel = '0; sel8 = '0; in_bus = '0; bus8 = '0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        rst = 1'b0;

        in_bus = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int k = 0; k < 8; k++) bus8[k*8 +: 8] = 8'(8'h10 + k);
        en = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel  = 2'(i % 3);
            sel8 = 3'(i);
            step();
        end

        sel = 2'b11;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();

        in_valid = 1'b1; sel = 2'd0; step();
        sel = 2'd1; step();
        flush = 1'b1; en = 1'b0; sel = 2'd2; step();
        flush = 1'b0; en = 1'b1; in_valid = 1'b0; step();
        step();

        in_valid = 1'b1; sel = 2'd0; step();
        sel = 2'd1; step();
        en = 1'b0; sel = 2'd2; sel8 = 3'd5; step();
        step();
        en = 1'b1; sel = 2'd2; step();
        in_valid = 1'b0; step();
        step();

        in_valid = 1'b1; sel = 2'd1; step();
        sel = 2'd2; step();
        async_reset();
        sel = 2'd0; step();
        in_valid = 1'b0; step();
        step();

        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            sel      = 2'($urandom_range(0, 3));
            sel8     = 3'($urandom_range(0, 7));
            in_bus   = {16'($urandom), 16'($urandom), 16'($urandom)};
            bus8     = {$urandom, $urandom};
            step();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_n_1_pipe.md
Name: mux_n_1_pipe

Overview:
- Parametrised N:1 data selector with registered output pipeline, stall and flush; successor to the fixed 3-input, 3-bit combinational selectors in the datapath.
- Used at pipeline boundaries of the 16-bit MIPS core (forwarding / writeback select), where the mux output must be registered and must obey stall and flush.
- Out-of-range select yields zero, as in the existing selectors, and raises an error flag.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- N_IN, 3, number of data inputs (2..16).
- LATENCY, 1, number of register stages from input to output (1 or 2; any other value is an elaboration error).
- SEL_W (localparam), clog2(N_IN) with a minimum of 1, select width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  stage enable; 0 = stall (all stages hold).
- flush  in  1  clears all stages' valid, data and error at the next edge.
- in_valid  in  1  qualifies sel/in_bus this cycle.
- sel  in  SEL_W  input index.
- in_bus  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out  out  WIDTH  selected data after LATENCY cycles.
- out_valid  out  1  out carries a valid word.
- sel_err  out  1  out-of-range select indication (see Optional Feature).

Behaviour:
- Reset: while rst is high, every stage register clears asynchronously. out=0, out_valid=0, sel_err=0.
- Stage-1 next value:
  - in_valid=1 and sel<N_IN: data=input[sel], valid=1, err=0.
  - in_valid=1 and sel>=N_IN: data=0, valid=1, err=1.
  - in_valid=0: data=0, valid=0, err=0.
- Stage 2 (LATENCY=2 only) copies stage 1.
- out, out_valid and sel_err are driven directly from the last stage. No combinational path from inputs to outputs.
- Latency: a word presented at edge t appears at the outputs after edge t+LATENCY-1, counting enabled edges only.
- Stall: en=0 holds all stages unchanged. Inputs presented during a stall are discarded.
- Flush: flush=1 zeroes all stages at the next edge, independent of en. flush has priority over en and over new input.
- Simultaneous flush and in_valid: the input is dropped; the output is 0/invalid after the edge.
- Reset mid-stream: in-flight words are lost. The first valid output after reset release appears LATENCY enabled edges after the first valid input.
- Select width: when N_IN is not a power of two, sel values N_IN..2^SEL_W-1 are out of range. For N_IN=3, sel=2'b11 gives data 0 and err=1.
- Throughput: one word per enabled cycle. No backpressure beyond en.

Optional Feature:
- Macro: MUX_SEL_ERR_STICKY_EN.
- Defined: sel_err is a sticky flag. It sets when an err=1 word reaches the last stage and stays high until rst or flush. It is unaffected by en.
- Undefined: sel_err equals the last stage's err bit. It is high only while the offending word is at out, and is therefore always 0 when out_valid=0.

Decomposition:
- Package mux_pkg:
  - MUX_DEF_WIDTH=16 and MUX_MAX_IN=16 constants.
  - A sel-width function (clog2 with minimum 1).
  - Packed struct stage_t {valid, err, data[WIDTH]} used for stage registers.
- Sub-module mux_pipe_stage:
  - One register stage with clk, rst, en, flush, d, q.
  - Instantiated LATENCY times in a generate loop.
- Select and out-of-range decode stay in the top module.

Test Plan (WIDTH=16, N_IN=3 unless stated):
- LATENCY=1. in_bus={16'hCCCC,16'hBBBB,16'hAAAA}, in_valid=1, sel cycling 0,1,2 on consecutive edges -> out AAAA,BBBB,CCCC one cycle later each, out_valid=1, sel_err=0.
- sel=2'b11, in_valid=1 -> out=0000, out_valid=1, sel_err=1 for one cycle. With MUX_SEL_ERR_STICKY_EN defined, sel_err stays 1 until flush.
- LATENCY=2, stream sel=0,1,2 with en=0 for 2 cycles mid-stream -> outputs hold during stall; sequence AAAA,BBBB,CCCC intact with 2-cycle latency, no duplicates or drops.
- LATENCY=2, two valid words in flight, then flush=1 with en=0 and in_valid=1 -> next edge out=0, out_valid=0, sel_err=0; the word presented with flush never appears.
- Assert rst asynchronously between clock edges with valid data in flight -> out, out_valid and sel_err are 0 immediately, before the next clk edge. After release, the first output appears LATENCY edges after the first valid input.
- N_IN=8, WIDTH=8, sel sweep 0..7 with in_bus input k = 8'h10+k -> out 10..17 in order, sel_err never set.
